reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-read-port register file for the pipelined CPU's decode stage. It has one synchronous write port, NUM_RD registered read ports and an optional hardwired-zero entry 0. A sequential clear engine sweeps every entry to zero after reset or on request, and an optional write-to-read bypass replaces the external NOP padding the pipeline needs today.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of entries (power of two, ≥ 4)
- NUM_RD, 2, number of read ports (1–4)
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes

Ports (ADDR_W = $clog2(DEPTH)):
- CLK  in  1  single clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- IN  in  DATA_W  write data
- INADDRESS  in  ADDR_W  write address
- WRITEENABLE  in  1  write strobe, sampled at rising CLK
- OUTADDRESS  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- OUT  out  NUM_RD*DATA_W  registered read data; port k uses bits [k*DATA_W +: DATA_W]
- CLEAR  in  1  request a full clear sweep, single-cycle pulse
- BUSY  out  1  clear sweep in progress
- WRITE_DROP  out  1  one-cycle pulse: a write was rejected during BUSY

## Operation
- Clear engine states:
  - IDLE: normal operation.
  - SWEEP: counter clr_ptr walks 0..DEPTH-1, writing zero to one entry per cycle.
- Transitions:
  - RESET=1 forces SWEEP with clr_ptr=0. The engine stays there without advancing while RESET is held.
  - In SWEEP, clr_ptr increments every cycle RESET=0. At clr_ptr==DEPTH-1 it writes that entry and goes to IDLE.
  - CLEAR=1 in IDLE moves to SWEEP with clr_ptr=0. CLEAR in SWEEP is ignored; the sweep does not restart.
  - RESET during SWEEP restarts the sweep from clr_ptr=0.
- BUSY = (state==SWEEP).
- Write: at rising CLK, if WRITEENABLE and state==IDLE and !RESET, then regs[INADDRESS] <= IN. With ZERO_REG=1, a write to address 0 is discarded silently and WRITE_DROP is not pulsed.
- WRITE_DROP <= WRITEENABLE && BUSY, registered. A dropped write is never replayed.
- Read: at each rising CLK, OUT[k] <= regs[OUTADDRESS[k]]. OUT[k] is forced to 0 when ZERO_REG=1 and the address is 0, or when BUSY or RESET is asserted.
- Duplicate read addresses across ports are legal and return identical data.
- No arithmetic beyond the clr_ptr increment. clr_ptr is ADDR_W bits and the terminal compare stops it, so it never wraps.

## Timing
- Reset values (cycle after RESET sampled high): every OUT = 0, BUSY = 1, WRITE_DROP = 0, state = SWEEP, clr_ptr = 0.
- Clear duration: exactly DEPTH cycles of BUSY after RESET falls or after CLEAR is sampled. The first write is accepted on the cycle after BUSY deasserts.
- Read latency: 1 cycle. An address applied before edge n appears on OUT after edge n.
- Write-then-read of the same address:
  - Without bypass: a read issued in the write's cycle returns the old value. A read issued the following cycle returns the new value.
  - With bypass: see Configuration.
- Simultaneous CLEAR and WRITEENABLE in IDLE: the write is dropped, WRITE_DROP pulses, and the sweep starts.
- Simultaneous RESET and WRITEENABLE: the write is dropped and WRITE_DROP stays 0 (reset has priority).

## Configuration
- REG_FILE_BYPASS_EN defined: if WRITEENABLE is accepted in a cycle and INADDRESS == OUTADDRESS[k] (and it is not the zero register), OUT[k] takes IN on that edge. Write-to-read distance becomes 0 cycles.
- REG_FILE_BYPASS_EN undefined: there is no forwarding path. OUT reflects the array contents before the edge, and the assembler must keep one-instruction spacing.

## Structure
- Package reg_file_pkg:
  - clr_state_t enum {IDLE, SWEEP}
  - function addr_w(depth) returning $clog2
  - localparam defaults DATA_W_DEF=32, DEPTH_DEF=32
- Sub-module reg_file_clr_seq: owns the state, clr_ptr, BUSY and the clear-write strobe and address. The top module holds the array, the read muxes, the bypass and WRITE_DROP.

## Test plan
- Reset → sweep: hold RESET for 3 cycles, then release. Required: BUSY high for exactly 32 cycles after release, OUT=0 throughout, and all 32 entries read 0 afterwards.
- Write/read: write 0xDEADBEEF to r5, then read r5 on port 0 and port 1 the next cycle. Required: both OUT = 0xDEADBEEF one cycle later.
- Zero register: write 0x12345678 to r0, then read r0. Required: OUT = 0 and WRITE_DROP = 0.
- Same-cycle write/read of r7 (0xA5A5A5A5 over an old value of 0x1):
  - With REG_FILE_BYPASS_EN: OUT = 0xA5A5A5A5.
  - Without it: OUT = 0x1, then 0xA5A5A5A5 on the next read.
- Write during sweep: pulse CLEAR with r3 = 0x55, then attempt a write to r3 while BUSY. Required: WRITE_DROP pulses for one cycle, and r3 reads 0 after the sweep.
- Reset mid-sweep: assert RESET at clr_ptr = 17. Required: the sweep restarts, and BUSY lasts 32 cycles from RESET release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear engine: walks clr_ptr over every entry after reset or a CLEAR request,
// producing one zero-write strobe per cycle and the BUSY flag.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = addr_w(DEPTH_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    // Next-state: sweep until the last entry, CLEAR only honoured in IDLE
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d   = SWEEP;
                    clr_ptr_d = '0;
                end
            end
            SWEEP: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_ptr_d = '0;
            end
        endcase
    end

    // State register; reset parks the sweep at entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SWEEP;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Outputs
    always_comb begin
        busy     = (state_q == SWEEP);
        clr_we   = (state_q == SWEEP) && !rst;
        clr_addr = clr_ptr_q;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with sequential clear engine.
// Optional write-to-read forwarding: define REG_FILE_BYPASS_EN.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = addr_w(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_W-1:0]        IN,
    input  logic [ADDR_W-1:0]        INADDRESS,
    input  logic                     WRITEENABLE,
    input  logic [NUM_RD*ADDR_W-1:0] OUTADDRESS,
    output logic [NUM_RD*DATA_W-1:0] OUT,
    input  logic                     CLEAR,
    output logic                     BUSY,
    output logic                     WRITE_DROP
);

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0] out_q, out_d;
    logic              drop_q, drop_d;

    logic              wr_acc;
    logic              wr_zero;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    reg_file_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk      (CLK),
        .rst      (RESET),
        .clear    (CLEAR),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Write path: a CLEAR arriving with a write starts the sweep and drops the write
    always_comb begin
        wr_zero = (ZERO_REG != 0) && (INADDRESS == '0);
        wr_acc  = WRITEENABLE && !busy && !RESET && !CLEAR;
        drop_d  = WRITEENABLE && !RESET && (busy || CLEAR);
        regs_d  = regs_q;
        if (clr_we) begin
            regs_d[clr_addr] = '0;
        end else if (wr_acc && !wr_zero) begin
            regs_d[INADDRESS] = IN;
        end
    end

    // Read muxes with optional forwarding and zero forcing
    always_comb begin
        out_d   = '0;
        rd_addr = '0;
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_addr = OUTADDRESS[k*ADDR_W +: ADDR_W];
            rd_data = regs_q[rd_addr];
`ifdef REG_FILE_BYPASS_EN
            if (wr_acc && !wr_zero && (INADDRESS == rd_addr)) begin
                rd_data = IN;
            end
`endif
            if (RESET || busy || ((ZERO_REG != 0) && (rd_addr == '0))) begin
                rd_data = '0;
            end
            out_d[k*DATA_W +: DATA_W] = rd_data;
        end
    end

    // Storage array; contents are zeroed by the sweep, not by reset
    always_ff @(posedge CLK) begin
        regs_q <= regs_d;
    end

    // Registered read data and drop pulse
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    // Outputs
    always_comb begin
        OUT        = out_q;
        BUSY       = busy;
        WRITE_DROP = drop_q;
    end

endmodule
